// File: rtl/slot_bus_master_if.sv
// Signal bundle between the slot bus master and its environment.
//
// Contents:
//   host command side : cmd_valid, cmd_ready, cmd_rnw, cmd_addr[7:0], cmd_wdata[7:0]
//   host response side: rsp_valid, rsp_rdata[7:0]
//   slot bus side     : card_reset_x, slot_x_int_x, clk_rw, ax_d, r_wx,
//                       ad_out[7:0], ad_oe_x, ad_in[7:0], int_x_in, irq_pending
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. The requester holds cmd_valid and the cmd_* fields
// stable until that edge, and cmd_valid may stay high into the next command.
// rsp_valid has no ready. It is a one-clock pulse that the host must take.
//
// Modports: master = the bus master (slot_bus_master); slave = the host/card
// environment that drives commands and the card-side inputs.
interface slot_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rnw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       card_reset_x;
  logic       slot_x_int_x;
  logic       clk_rw;
  logic       ax_d;
  logic       r_wx;
  logic [7:0] ad_out;
  logic       ad_oe_x;
  logic [7:0] ad_in;
  logic       int_x_in;
  logic       irq_pending;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, ad_in, int_x_in,
    output cmd_ready, rsp_valid, rsp_rdata, card_reset_x, slot_x_int_x,
           clk_rw, ax_d, r_wx, ad_out, ad_oe_x, irq_pending
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, ad_in, int_x_in,
    input  cmd_ready, rsp_valid, rsp_rdata, card_reset_x, slot_x_int_x,
           clk_rw, ax_d, r_wx, ad_out, ad_oe_x, irq_pending
  );
endinterface

// File: rtl/slot_bus_master.sv
// Monitor-side initiator for the BKM-68X slot bus. Each accepted host command
// becomes an address cycle followed by a data cycle (setup / strobe / hold each),
// then a gap with the slot deselected. Card interrupts are synchronized and
// reported as a level.
//
// Ports:
//   clk_50mhz_in : system clock
//   reset_x      : asynchronous active-low reset
//   bus          : slot_bus_master_if.master (command, response and slot bus signals)
//   fsm_state    : current FSM state encoding, for observation only
module slot_bus_master #(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 4,
  parameter int GAP_CYC    = 2,
  parameter int RESET_CYC  = 16
) (
  input  logic                clk_50mhz_in,
  input  logic                reset_x,
  slot_bus_master_if.master   bus,
  output logic [3:0]          fsm_state
);

  localparam int MAX_0   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_1   = (MAX_0 > HOLD_CYC) ? MAX_0 : HOLD_CYC;
  localparam int MAX_2   = (MAX_1 > GAP_CYC) ? MAX_1 : GAP_CYC;
  localparam int MAX_CYC = (MAX_2 > RESET_CYC) ? MAX_2 : RESET_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [3:0] {
    RST_HOLD = 4'd0,
    IDLE     = 4'd1,
    A_SETUP  = 4'd2,
    A_STROBE = 4'd3,
    A_HOLD   = 4'd4,
    D_SETUP  = 4'd5,
    D_STROBE = 4'd6,
    D_HOLD   = 4'd7,
    GAP      = 4'd8
  } state_t;

  state_t     state, next_state;
  cnt_t       cnt, next_cnt;
  logic       done;
  logic       accept;

  logic       rnw_q, rnw_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;
  logic [7:0] sample_q;
  logic       sample_en;
  logic       rsp_n;

  logic       slot_n, clk_rw_n, ax_d_n, r_wx_n, ad_oe_x_n;
  logic [7:0] ad_out_n;

  logic       int_sync1, int_sync2;

  // Counter value loaded on entry to a state: the state then lasts exactly
  // (value + 1) clocks, leaving when the counter reads zero.
  function automatic cnt_t reload(input state_t s);
    case (s)
      RST_HOLD:                   reload = cnt_t'(RESET_CYC - 1);
      A_SETUP,  D_SETUP:          reload = cnt_t'(SETUP_CYC - 1);
      A_STROBE, D_STROBE:         reload = cnt_t'(STROBE_CYC - 1);
      A_HOLD,   D_HOLD:           reload = cnt_t'(HOLD_CYC - 1);
      GAP:                        reload = cnt_t'(GAP_CYC - 1);
      default:                    reload = '0;
    endcase
  endfunction

  assign done      = (cnt == '0);
  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign fsm_state = state;

  // Next state and counter
  always_comb begin
    next_state = state;
    case (state)
      RST_HOLD: if (done)   next_state = IDLE;
      IDLE:     if (accept) next_state = A_SETUP;
      A_SETUP:  if (done)   next_state = A_STROBE;
      A_STROBE: if (done)   next_state = A_HOLD;
      A_HOLD:   if (done)   next_state = D_SETUP;
      D_SETUP:  if (done)   next_state = D_STROBE;
      D_STROBE: if (done)   next_state = D_HOLD;
      D_HOLD:   if (done)   next_state = GAP;
      GAP:      if (done)   next_state = IDLE;
      default:              next_state = RST_HOLD;
    endcase

    if (next_state != state) next_cnt = reload(next_state);
    else if (!done)          next_cnt = cnt - cnt_t'(1);
    else                     next_cnt = cnt;
  end

  // Command fields as they will be after this edge, so the first A_SETUP
  // clock already drives the newly accepted address.
  always_comb begin
    rnw_n   = accept ? bus.cmd_rnw   : rnw_q;
    addr_n  = accept ? bus.cmd_addr  : addr_q;
    wdata_n = accept ? bus.cmd_wdata : wdata_q;
  end

  // Bus output values for the state being entered; registered below so every
  // bus pin comes straight from a flop.
  always_comb begin
    slot_n    = 1'b1;
    clk_rw_n  = 1'b1;
    ax_d_n    = 1'b0;
    r_wx_n    = 1'b1;
    ad_oe_x_n = 1'b1;
    ad_out_n  = 8'h00;
    case (next_state)
      A_SETUP, A_STROBE, A_HOLD: begin
        slot_n    = 1'b0;
        r_wx_n    = 1'b0;
        ad_oe_x_n = 1'b0;
        ad_out_n  = addr_n;
        clk_rw_n  = (next_state != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        slot_n    = 1'b0;
        ax_d_n    = 1'b1;
        r_wx_n    = rnw_n;
        ad_oe_x_n = rnw_n;               // release ad for the card on reads
        ad_out_n  = rnw_n ? 8'h00 : wdata_n;
        clk_rw_n  = (next_state != D_STROBE);
      end
      default: ;
    endcase
  end

  // Read data is captured on the edge that ends the strobe (clk_rw rising).
  assign sample_en = (state == D_STROBE) && done;
  assign rsp_n     = (state == D_HOLD) && done;

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state            <= RST_HOLD;
      cnt              <= cnt_t'(RESET_CYC - 1);
      rnw_q            <= 1'b0;
      addr_q           <= 8'h00;
      wdata_q          <= 8'h00;
      sample_q         <= 8'h00;
      bus.card_reset_x <= 1'b0;
      bus.cmd_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= 8'h00;
      bus.slot_x_int_x <= 1'b1;
      bus.clk_rw       <= 1'b1;
      bus.ax_d         <= 1'b0;
      bus.r_wx         <= 1'b1;
      bus.ad_out       <= 8'h00;
      bus.ad_oe_x      <= 1'b1;
    end else begin
      state            <= next_state;
      cnt              <= next_cnt;
      rnw_q            <= rnw_n;
      addr_q           <= addr_n;
      wdata_q          <= wdata_n;
      if (sample_en) sample_q <= bus.ad_in;
      bus.card_reset_x <= (next_state != RST_HOLD);
      bus.cmd_ready    <= (next_state == IDLE);
      bus.rsp_valid    <= rsp_n;
      if (rsp_n) bus.rsp_rdata <= rnw_q ? sample_q : 8'h00;
      bus.slot_x_int_x <= slot_n;
      bus.clk_rw       <= clk_rw_n;
      bus.ax_d         <= ax_d_n;
      bus.r_wx         <= r_wx_n;
      bus.ad_out       <= ad_out_n;
      bus.ad_oe_x      <= ad_oe_x_n;
    end
  end

  // Interrupt synchronizer, independent of the FSM. Flops idle at 1 (no irq).
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      int_sync1 <= 1'b1;
      int_sync2 <= 1'b1;
    end else begin
      int_sync1 <= bus.int_x_in;
      int_sync2 <= int_sync1;
    end
  end

  assign bus.irq_pending = ~int_sync2;

endmodule
